// File: rtl/btpipe_out_fifo.sv
// btpipe_out_fifo: block-throttled output FIFO feeding an okBTPipeOut endpoint.
// A producer pushes 16-bit words. The host side only ever sees ep_ready=1 when
// a full block of BLOCK_WORDS words is guaranteed to be available.
// Optional build macro BTPIPE_OVF_COUNT_EN adds a saturating dropped-write
// counter on output ovf_count.
module btpipe_out_fifo #(
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  ti_clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [15:0]           wr_data,
    input  logic                  ep_read,
    input  logic                  ep_blockstrobe,
    output logic [15:0]           ep_datain,
    output logic                  ep_ready,
    output logic [DEPTH_LOG2:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
`ifdef BTPIPE_OVF_COUNT_EN
    ,
    output logic [15:0]           ovf_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Occupancy and block-length constants sized to the counters they are compared with
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   BW       = (DEPTH_LOG2 + 1)'(BLOCK_WORDS);
    localparam logic [DEPTH_LOG2+1:0] BW_X     = (DEPTH_LOG2 + 2)'(BLOCK_WORDS);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;

    logic [15:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   fill_q, fill_d;
    logic [DEPTH_LOG2:0]   rem_q, rem_d;
    logic [1:0]            state_q, state_d;
    logic [15:0]           dout_q, dout_d;
    logic                  ready_q, ready_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
`ifdef BTPIPE_OVF_COUNT_EN
    logic [15:0]           ovf_cnt_q, ovf_cnt_d;
`endif

    logic                  wr_ok;
    logic                  wr_drop;
    logic                  rd_ok;

    // Qualify the strobes; clear overrides everything in its cycle
    always_comb begin
        wr_ok   = wr_en && (fill_q != FULL_CNT) && !clear;
        wr_drop = wr_en && (fill_q == FULL_CNT) && !clear;
        rd_ok   = ep_read && (state_q == ST_XFER) && (fill_q != '0) && !clear;
    end

    // Next-state logic: pointers, occupancy, flags and the block state machine
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        rem_d     = rem_q;
        state_d   = state_q;
        dout_d    = dout_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ready_d   = 1'b0;
`ifdef BTPIPE_OVF_COUNT_EN
        ovf_cnt_d = ovf_cnt_q;
`endif
        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            fill_d    = '0;
            rem_d     = '0;
            state_d   = ST_IDLE;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
`ifdef BTPIPE_OVF_COUNT_EN
            ovf_cnt_d = '0;
`endif
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                dout_d   = mem[rd_ptr_q];
            end
            if (wr_ok && !rd_ok)      fill_d = fill_q + CNT_ONE;
            else if (rd_ok && !wr_ok) fill_d = fill_q - CNT_ONE;

            if (wr_drop) begin
                ovf_d = 1'b1;
`ifdef BTPIPE_OVF_COUNT_EN
                if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
`endif
            end
            // Illegal read (empty or not in a transfer) or a strobe outside ARMED
            if ((ep_read && !rd_ok) || (ep_blockstrobe && state_q != ST_ARMED))
                unf_d = 1'b1;

            unique case (state_q)
                ST_IDLE: begin
                    if (fill_q >= BW) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (ep_blockstrobe) begin
                        state_d = ST_XFER;
                        rem_d   = BW;
                    end
                end
                ST_XFER: begin
                    if (rd_ok) begin
                        rem_d = rem_q - CNT_ONE;
                        // Last word of the block: re-arm only if another block is already queued
                        if (rem_q == CNT_ONE)
                            state_d = (fill_d >= BW) ? ST_ARMED : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // In XFER, ready only when the words beyond this block already form a full block
            ready_d = (state_d == ST_ARMED) ||
                      ((state_d == ST_XFER) && ({1'b0, fill_d} >= ({1'b0, rem_d} + BW_X)));
        end
    end

    // RAM write port; contents need no reset
    always_ff @(posedge ti_clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data;
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            rem_q     <= '0;
            state_q   <= ST_IDLE;
            dout_q    <= '0;
            ready_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
`ifdef BTPIPE_OVF_COUNT_EN
            ovf_cnt_q <= '0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            rem_q     <= rem_d;
            state_q   <= state_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
`ifdef BTPIPE_OVF_COUNT_EN
            ovf_cnt_q <= ovf_cnt_d;
`endif
        end
    end

    assign ep_datain  = dout_q;
    assign ep_ready   = ready_q;
    assign fill_count = fill_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
`ifdef BTPIPE_OVF_COUNT_EN
    assign ovf_count  = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_btpipe_out_fifo.sv
// Bench for btpipe_out_fifo with DEPTH_LOG2=3, BLOCK_WORDS=4: a vector table,
// hand-written multi-cycle sequences and a randomized run against a queue model.
module tb_btpipe_out_fifo;

    localparam int DL    = 3;
    localparam int BWN   = 4;
    localparam int DEPTH = 1 << DL;

    logic          ti_clk = 1'b0;
    logic          rst_n;
    logic          clear, wr_en, ep_read, ep_blockstrobe;
    logic [15:0]   wr_data;
    logic [15:0]   ep_datain;
    logic          ep_ready, overflow, underflow;
    logic [DL:0]   fill_count;
`ifdef BTPIPE_OVF_COUNT_EN
    logic [15:0]   ovf_count;
`endif

    btpipe_out_fifo #(.DEPTH_LOG2(DL), .BLOCK_WORDS(BWN)) dut (
        .ti_clk(ti_clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en),
        .wr_data(wr_data), .ep_read(ep_read), .ep_blockstrobe(ep_blockstrobe),
        .ep_datain(ep_datain), .ep_ready(ep_ready), .fill_count(fill_count),
        .overflow(overflow), .underflow(underflow)
`ifdef BTPIPE_OVF_COUNT_EN
        , .ovf_count(ovf_count)
`endif
    );

    always #5 ti_clk = ~ti_clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_ARMED, M_XFER} mst_t;
    logic [15:0] mq[$];
    mst_t        mst;
    int          mrem, movfc;
    logic [15:0] mdout;
    bit          movf, munf;

    task automatic mdl_reset();
        mq.delete(); mst = M_IDLE; mrem = 0; movfc = 0;
        mdout = '0; movf = 0; munf = 0;
    endtask

    task automatic mdl_step(input bit c, input bit w, input logic [15:0] d,
                            input bit r, input bit b);
        int  old;
        bit  legal;
        if (c) begin
            mq.delete(); mst = M_IDLE; mrem = 0; movfc = 0; movf = 0; munf = 0;
            return;
        end
        old   = mq.size();
        legal = r && (mst == M_XFER) && (old > 0);
        if (r && !legal) munf = 1;
        if (b && mst != M_ARMED) munf = 1;
        if (legal) mdout = mq.pop_front();
        if (w) begin
            if (old < DEPTH) mq.push_back(d);
            else begin movf = 1; if (movfc < 65535) movfc++; end
        end
        case (mst)
            M_IDLE:  if (old >= BWN) mst = M_ARMED;
            M_ARMED: if (b) begin mst = M_XFER; mrem = BWN; end
            M_XFER:  if (legal) begin
                         mrem--;
                         if (mrem == 0) mst = (mq.size() >= BWN) ? M_ARMED : M_IDLE;
                     end
            default: mst = M_IDLE;
        endcase
    endtask

    function automatic bit m_ready();
        return (mst == M_ARMED) || (mst == M_XFER && mq.size() >= mrem + BWN);
    endfunction

    // One clock cycle: drive, clock, sample 1 time unit after the edge, step model
    task automatic cyc(input bit c, input bit w, input logic [15:0] d,
                       input bit r, input bit b);
        clear = c; wr_en = w; wr_data = d; ep_read = r; ep_blockstrobe = b;
        @(posedge ti_clk);
        #1;
        mdl_step(c, w, d, r, b);
        clear = 0; wr_en = 0; ep_read = 0; ep_blockstrobe = 0;
    endtask

    task automatic chk_out(input string nm, input int f, input bit rdy,
                           input int dout, input bit o, input bit u);
        chk({nm, ".fill"},  int'(fill_count), f);
        chk({nm, ".ready"}, int'(ep_ready),   int'(rdy));
        chk({nm, ".dout"},  int'(ep_datain),  dout);
        chk({nm, ".ovf"},   int'(overflow),   int'(o));
        chk({nm, ".unf"},   int'(underflow),  int'(u));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit c, w; logic [15:0] d; bit r, b;
        int f; bit rdy; int dout; bit o, u;
    } vec_t;
    localparam int NV = 13;
    vec_t vecs[NV];

    // Watchdog: all waits are fixed cycle counts, this only guards a stuck simulator
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //         c w d      r b   fill rdy dout o u
        vecs[0]  = '{0,0,16'h0,0,0, 0,0,0,     0,0};
        vecs[1]  = '{0,1,16'h1,0,0, 1,0,0,     0,0};
        vecs[2]  = '{0,1,16'h2,0,0, 2,0,0,     0,0};
        vecs[3]  = '{0,1,16'h3,0,0, 3,0,0,     0,0};
        vecs[4]  = '{0,1,16'h4,0,0, 4,0,0,     0,0};
        vecs[5]  = '{0,0,16'h0,0,0, 4,1,0,     0,0};
        vecs[6]  = '{0,0,16'h0,0,1, 4,0,0,     0,0};
        vecs[7]  = '{0,0,16'h0,1,0, 3,0,1,     0,0};
        vecs[8]  = '{0,0,16'h0,1,0, 2,0,2,     0,0};
        vecs[9]  = '{0,0,16'h0,1,0, 1,0,3,     0,0};
        vecs[10] = '{0,0,16'h0,1,0, 0,0,4,     0,0};
        vecs[11] = '{0,0,16'h0,1,0, 0,0,4,     0,1};
        vecs[12] = '{1,0,16'h0,0,0, 0,0,4,     0,0};

        rst_n = 0; clear = 0; wr_en = 0; wr_data = 0; ep_read = 0; ep_blockstrobe = 0;
        mdl_reset();
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);
`ifdef BTPIPE_OVF_COUNT_EN
        chk("reset.ovfc", int'(ovf_count), 0);
`endif
        repeat (2) @(posedge ti_clk);
        #1 rst_n = 1;

        // Fill, single block transfer, illegal read, clear
        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].c, vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].b);
            chk_out($sformatf("vec%0d", i), vecs[i].f, vecs[i].rdy,
                    vecs[i].dout, vecs[i].o, vecs[i].u);
        end

        // Back-to-back blocks: ready stays high through the whole transfer
        for (int i = 0; i < 8; i++) cyc(0, 1, 16'h10 + 16'(i), 0, 0);
        chk_out("b2b.filled", 8, 1, 4, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("b2b.strobe.ready", int'(ep_ready), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk_out($sformatf("b2b.rd%0d", i), 7 - i, 1, 16'h10 + i, 0, 0);
        end
        cyc(0, 0, 0, 1, 0);  // read in ARMED is illegal
        chk_out("b2b.armed_rd", 4, 1, 16'h13, 0, 1);
        cyc(1, 0, 0, 0, 0);

        // Overflow: ninth word dropped and never read back
        for (int i = 0; i < 9; i++) cyc(0, 1, 16'h20 + 16'(i), 0, 0);
        chk_out("ovf.filled", 8, 1, 16'h13, 1, 0);
`ifdef BTPIPE_OVF_COUNT_EN
        chk("ovf.count", int'(ovf_count), 1);
`endif
        for (int blk = 0; blk < 2; blk++) begin
            cyc(0, 0, 0, 0, 1);
            for (int i = 0; i < 4; i++) begin
                cyc(0, 0, 0, 1, 0);
                chk($sformatf("ovf.b%0d.rd%0d", blk, i), int'(ep_datain), 16'h20 + blk * 4 + i);
            end
        end
        chk_out("ovf.drained", 0, 0, 16'h27, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk_out("ovf.extra_rd", 0, 0, 16'h27, 1, 1);
        cyc(1, 0, 0, 0, 0);
        chk_out("ovf.clear", 0, 0, 16'h27, 0, 0);

        // Clear mid-transfer, with a concurrent write that must be discarded silently
        for (int i = 0; i < 9; i++) cyc(0, 1, 16'h30 + 16'(i), 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);  // strobe in XFER
        chk_out("clr.pre", 6, 1, 16'h31, 1, 1);
        cyc(1, 1, 16'hBEEF, 0, 0);
        chk_out("clr.post", 0, 0, 16'h31, 0, 0);
`ifdef BTPIPE_OVF_COUNT_EN
        chk("clr.ovfc", int'(ovf_count), 0);
`endif
        cyc(0, 0, 0, 0, 1);  // strobe in IDLE
        chk_out("clr.idle_bs", 0, 0, 16'h31, 0, 1);
        cyc(1, 0, 0, 0, 0);

        // Asynchronous reset mid-transfer
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'h40 + 16'(i), 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk_out("rst.pre", 2, 0, 16'h41, 0, 1);
        rst_n = 0;
        mdl_reset();
        #1;
        chk_out("rst.async", 0, 0, 0, 0, 0);
        repeat (2) @(posedge ti_clk);
        #1 rst_n = 1;
        cyc(0, 1, 16'h50, 0, 0);
        chk_out("rst.after_wr", 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk_out("rst.idle_rd", 1, 0, 0, 0, 1);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            int  phase;
            bit  c, w, r, b;
            phase = (i / 200) % 3;
            c = ($urandom_range(99) == 0);
            w = (phase == 0) ? ($urandom_range(3) != 0) : ($urandom_range(1) == 1);
            r = (phase == 2) ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
            b = ($urandom_range(5) == 0);
            cyc(c, w, 16'($urandom), r, b);
            chk_out($sformatf("rnd%0d", i), mq.size(), m_ready(), int'(mdout), movf, munf);
`ifdef BTPIPE_OVF_COUNT_EN
            chk($sformatf("rnd%0d.ovfc", i), int'(ovf_count), movfc);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
